pc_sequencer: RTL and testbench

//  Program-counting unit of the 16-bit processor. Holds the program counter (PC) and the

---
 rtl/pc_pkg.sv | 11 +
 rtl/pc_incr_adder.sv | 13 +
 rtl/pc_sequencer.sv | 81 ++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counting unit.
// Datapath width and reset value of the program counter.
package pc_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t PC_RESET_VAL = 16'h0000;

endpackage

// File: rtl/pc_incr_adder.sv
// Plain W-bit adder used to form PC+1.
// The carry out is dropped, so the sum wraps modulo 2^W.
module pc_incr_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and return-address register with next-PC selection.
// PC+1 is exported combinationally for the rest of the datapath.
module pc_sequencer #(
  parameter int WIDTH = pc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restore,
  input  logic             writePC,
  input  logic             writeRA,
  input  logic             PCsrc,
  input  logic             ImRPC,
  input  logic             conditionalBop,
  input  logic [WIDTH-1:0] RArestore,
  input  logic [WIDTH-1:0] ImR,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_1,
  output logic [WIDTH-1:0] RA
);

  import pc_pkg::*;

  localparam logic [WIDTH-1:0] ONE = 1;
  localparam logic [WIDTH-1:0] RST = WIDTH'(PC_RESET_VAL);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] seq_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ra_next;
  logic             pc_we;
  logic             take_imm;

  pc_incr_adder #(
    .W(WIDTH)
  ) u_incr (
    .a  (pc_q),
    .b  (ONE),
    .sum(pc_inc)
  );

  // A taken branch both selects ImR and forces the PC write.
  assign take_imm = ImRPC | conditionalBop;
  assign pc_we    = writePC | conditionalBop;

  always_comb begin
    seq_next = pc_inc;
    if (take_imm)
      seq_next = ImR;
  end

  always_comb begin
    pc_next = seq_next;
    if (PCsrc)
      pc_next = ra_q;
  end

  always_comb begin
    ra_next = pc_inc;
    if (restore)
      ra_next = RArestore;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RST;
      ra_q <= '0;
    end else begin
      if (pc_we)
        pc_q <= pc_next;
      if (writeRA)
        ra_q <= ra_next;
    end
  end

  assign PC   = pc_q;
  assign RA   = ra_q;
  assign PC_1 = pc_inc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table,
// hand-written reset/hold sequences and a randomized reference-model run.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restore = 1'b0;
  logic        writePC = 1'b0;
  logic        writeRA = 1'b0;
  logic        PCsrc = 1'b0;
  logic        ImRPC = 1'b0;
  logic        conditionalBop = 1'b0;
  logic [15:0] RArestore = '0;
  logic [15:0] ImR = '0;
  logic [15:0] PC;
  logic [15:0] PC_1;
  logic [15:0] RA;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .restore       (restore),
    .writePC       (writePC),
    .writeRA       (writeRA),
    .PCsrc         (PCsrc),
    .ImRPC         (ImRPC),
    .conditionalBop(conditionalBop),
    .RArestore     (RArestore),
    .ImR           (ImR),
    .PC            (PC),
    .PC_1          (PC_1),
    .RA            (RA)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wpc;
    bit          wra;
    bit          psrc;
    bit          imr;
    bit          cb;
    bit          rs;
    logic [15:0] imm;
    logic [15:0] rar;
    logic [15:0] exp_pc;
    logic [15:0] exp_ra;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string n, bit wpc, bit wra, bit psrc,
                              bit imr, bit cb, bit rs,
                              logic [15:0] imm, logic [15:0] rar,
                              logic [15:0] epc, logic [15:0] era);
    vec_t v;
    v.name = n; v.wpc = wpc; v.wra = wra; v.psrc = psrc;
    v.imr = imr; v.cb = cb; v.rs = rs; v.imm = imm; v.rar = rar;
    v.exp_pc = epc; v.exp_ra = era;
    return v;
  endfunction

  task automatic check(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(bit wpc, bit wra, bit psrc, bit imr, bit cb,
                       bit rs, logic [15:0] imm, logic [15:0] rar);
    writePC = wpc; writeRA = wra; PCsrc = psrc; ImRPC = imr;
    conditionalBop = cb; restore = rs; ImR = imm; RArestore = rar;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference state kept as plain integers, wrapped by modulo 65536.
  int m_pc;
  int m_ra;

  task automatic model_step(bit wpc, bit wra, bit psrc, bit imr, bit cb,
                            bit rs, int imm, int rar);
    int inc;
    int tgt;
    int nra;
    inc = (m_pc + 1) % 65536;
    if (psrc)           tgt = m_ra;
    else if (imr || cb) tgt = imm;
    else                tgt = inc;
    nra = rs ? rar : inc;
    if (wpc || cb) m_pc = tgt;
    if (wra)       m_ra = nra;
  endtask

  initial begin
    vecs[0]  = mk("seq1",      1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0001, 16'h0000);
    vecs[1]  = mk("seq2",      1,0,0,0,0,0, 16'hAAAA, 16'h0000, 16'h0002, 16'h0000);
    vecs[2]  = mk("seq3",      1,0,0,0,0,0, 16'h0000, 16'h5555, 16'h0003, 16'h0000);
    vecs[3]  = mk("jump",      1,0,0,1,0,0, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
    vecs[4]  = mk("branch",    0,0,0,0,1,0, 16'h0200, 16'h0000, 16'h0200, 16'h0000);
    vecs[5]  = mk("jump10",    1,0,0,1,0,0, 16'h0010, 16'h0000, 16'h0010, 16'h0000);
    vecs[6]  = mk("call",      1,1,0,1,0,0, 16'h0300, 16'h1111, 16'h0300, 16'h0011);
    vecs[7]  = mk("return",    1,0,1,0,0,0, 16'h7777, 16'h0000, 16'h0011, 16'h0011);
    vecs[8]  = mk("restore",   0,1,0,0,0,1, 16'h0000, 16'hBEEF, 16'h0011, 16'hBEEF);
    vecs[9]  = mk("ret_call",  1,1,1,0,0,0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0012);
    vecs[10] = mk("jumpFFFF",  1,0,0,1,0,0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0012);
    vecs[11] = mk("wrap",      1,0,0,0,0,0, 16'h1234, 16'h0000, 16'h0000, 16'h0012);
    vecs[12] = mk("psrc_nowr", 0,0,1,1,0,1, 16'h4321, 16'h9999, 16'h0000, 16'h0012);
    vecs[13] = mk("psrc_cb",   0,0,1,0,1,0, 16'h4444, 16'h0000, 16'h0012, 16'h0012);

    // Reset held from time 0
    #12;
    check("reset_pc", PC, 16'h0000);
    check("reset_ra", RA, 16'h0000);
    check("reset_pc1", PC_1, 16'h0001);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].wpc, vecs[i].wra, vecs[i].psrc, vecs[i].imr,
            vecs[i].cb, vecs[i].rs, vecs[i].imm, vecs[i].rar);
      if (vecs[i].name == "wrap")
        check("wrap_pre_pc1", PC_1, 16'h0000);
      tick();
      check({vecs[i].name, "_pc"}, PC, vecs[i].exp_pc);
      check({vecs[i].name, "_ra"}, RA, vecs[i].exp_ra);
      check({vecs[i].name, "_pc1"}, PC_1, vecs[i].exp_pc + 16'd1);
    end

    // Asynchronous reset asserted mid-cycle
    drive(1,0,0,1,0,0, 16'h0042, 16'h0000);
    tick();
    check("pre_rst_pc", PC, 16'h0042);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_pc", PC, 16'h0000);
    check("async_rst_ra", RA, 16'h0000);
    check("async_rst_pc1", PC_1, 16'h0001);
    drive(1,1,0,1,1,1, 16'h0055, 16'h0066);
    tick();
    check("rst_hold_pc", PC, 16'h0000);
    check("rst_hold_ra", RA, 16'h0000);
    #2;
    reset = 1'b1;

    // Load known values, then hold across 5 edges
    drive(1,1,0,1,0,1, 16'h1234, 16'h5678);
    tick();
    check("load_pc", PC, 16'h1234);
    check("load_ra", RA, 16'h5678);
    for (int k = 0; k < 5; k++) begin
      drive(0,0,k[0],~k[0],0,k[1], 16'($urandom), 16'($urandom));
      tick();
      check("hold_pc", PC, 16'h1234);
      check("hold_ra", RA, 16'h5678);
    end

    // Randomized run against the reference model
    m_pc = 'h1234;
    m_ra = 'h5678;
    for (int n = 0; n < 400; n++) begin
      bit wpc, wra, psrc, imr, cb, rs;
      logic [15:0] imm, rar;
      wpc  = 1'($urandom);
      wra  = 1'($urandom);
      psrc = ($urandom_range(0, 3) == 0);
      imr  = ($urandom_range(0, 3) == 0);
      cb   = ($urandom_range(0, 4) == 0);
      rs   = 1'($urandom);
      imm  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rar  = 16'($urandom);
      drive(wpc, wra, psrc, imr, cb, rs, imm, rar);
      model_step(wpc, wra, psrc, imr, cb, rs, int'(imm), int'(rar));
      tick();
      check("rand_pc", PC, 16'(m_pc));
      check("rand_ra", RA, 16'(m_ra));
      check("rand_pc1", PC_1, 16'((m_pc + 1) % 65536));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
